uc_control: RTL and testbench

UC_CONTROL -- requirements
Module: uc_control

---
 rtl/uc_control.sv | 118 +++++++++++
 tb/tb_uc_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uc_control.sv
// Main-decoder control unit: maps the decode-stage opcode to registered datapath
// control signals with one cycle of latency; reset loads the NOP (addi x0,x0,0) vector.
module uc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode_d,
    output logic       regwrite_d,
    output logic [3:0] aluop_d,
    output logic       luisrc_d,
    output logic       alusrc_d,
    output logic       memwrite_d,
    output logic       memread_d,
    output logic [1:0] memtoreg_d,
    output logic       jumppc_d,
    output logic       jumpcontrol_d,
    output logic       bne_d
);

    typedef enum logic [6:0] {
        OP_BUBBLE = 7'b0000000,
        OP_LOAD   = 7'b0000011,
        OP_ALUI   = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_ALUR   = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_t;

    typedef struct packed {
        logic       regwrite;
        logic [3:0] aluop;
        logic       luisrc;
        logic       alusrc;
        logic       memwrite;
        logic       memread;
        logic [1:0] memtoreg;
        logic       jumppc;
        logic       jumpcontrol;
        logic       bne;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        regwrite: 1'b1, aluop: 4'b0111, luisrc: 1'b1, alusrc: 1'b1,
        memwrite: 1'b0, memread: 1'b0, memtoreg: 2'b00,
        jumppc: 1'b0, jumpcontrol: 1'b0, bne: 1'b0
    };

    ctrl_t ctrl_next;
    ctrl_t ctrl_q;

    always_comb begin
        // Unlisted opcodes fall through to the all-zero vector with no side effects.
        ctrl_next = '0;
        case (opcode_d)
            OP_ALUR: begin
                ctrl_next.regwrite = 1'b1;
                ctrl_next.aluop    = 4'b0110;
                ctrl_next.luisrc   = 1'b1;
            end
            OP_ALUI, OP_BUBBLE: begin
                ctrl_next = CTRL_NOP;
            end
            OP_LOAD: begin
                ctrl_next.regwrite = 1'b1;
                ctrl_next.luisrc   = 1'b1;
                ctrl_next.alusrc   = 1'b1;
                ctrl_next.memread  = 1'b1;
                ctrl_next.memtoreg = 2'b01;
            end
            OP_STORE: begin
                ctrl_next.luisrc   = 1'b1;
                ctrl_next.alusrc   = 1'b1;
                ctrl_next.memwrite = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_next.aluop  = 4'b0001;
                ctrl_next.luisrc = 1'b1;
                ctrl_next.bne    = 1'b1;
            end
            OP_LUI: begin
                ctrl_next.regwrite = 1'b1;
                ctrl_next.aluop    = 4'b0010;
                ctrl_next.alusrc   = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                ctrl_next.regwrite    = 1'b1;
                ctrl_next.luisrc      = 1'b1;
                ctrl_next.alusrc      = 1'b1;
                ctrl_next.memtoreg    = 2'b10;
                ctrl_next.jumppc      = 1'b1;
                ctrl_next.jumpcontrol = (opcode_d == OP_JALR);
            end
            default: ctrl_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_next;
        end
    end

    assign regwrite_d    = ctrl_q.regwrite;
    assign aluop_d       = ctrl_q.aluop;
    assign luisrc_d      = ctrl_q.luisrc;
    assign alusrc_d      = ctrl_q.alusrc;
    assign memwrite_d    = ctrl_q.memwrite;
    assign memread_d     = ctrl_q.memread;
    assign memtoreg_d    = ctrl_q.memtoreg;
    assign jumppc_d      = ctrl_q.jumppc;
    assign jumpcontrol_d = ctrl_q.jumpcontrol;
    assign bne_d         = ctrl_q.bne;

endmodule

// File: tb/tb_uc_control.sv
// Scoreboard bench for uc_control: opcode table reference model, directed
// sequences, exhaustive opcode sweep and randomized opcode/reset traffic.
module tb_uc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode_d;
    logic       regwrite_d;
    logic [3:0] aluop_d;
    logic       luisrc_d;
    logic       alusrc_d;
    logic       memwrite_d;
    logic       memread_d;
    logic [1:0] memtoreg_d;
    logic       jumppc_d;
    logic       jumpcontrol_d;
    logic       bne_d;

    always #5 clk = ~clk;

    uc_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_d     (opcode_d),
        .regwrite_d   (regwrite_d),
        .aluop_d      (aluop_d),
        .luisrc_d     (luisrc_d),
        .alusrc_d     (alusrc_d),
        .memwrite_d   (memwrite_d),
        .memread_d    (memread_d),
        .memtoreg_d   (memtoreg_d),
        .jumppc_d     (jumppc_d),
        .jumpcontrol_d(jumpcontrol_d),
        .bne_d        (bne_d)
    );

    // Packed order: regwrite, aluop, luisrc, alusrc, memwrite, memread, memtoreg, jumppc, jumpcontrol, bne
    logic [13:0] act;
    assign act = {regwrite_d, aluop_d, luisrc_d, alusrc_d, memwrite_d, memread_d,
                  memtoreg_d, jumppc_d, jumpcontrol_d, bne_d};

    localparam logic [13:0] NOP = 14'b1_0111_1_1_0_0_00_0_0_0;

    typedef struct {
        logic [13:0] vec;
        logic [6:0]  op;
        logic        r;
    } exp_t;

    exp_t        sb[$];
    logic [13:0] table_m [logic [6:0]];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic logic [13:0] model(input logic r, input logic [6:0] op);
        if (r) return NOP;
        if (table_m.exists(op)) return table_m[op];
        return 14'b0;
    endfunction

    task automatic apply(input logic r, input logic [6:0] op);
        exp_t e;
        @(negedge clk);
        rst      = r;
        opcode_d = op;
        e.vec = model(r, op);
        e.op  = op;
        e.r   = r;
        sb.push_back(e);
    endtask

    // Monitor: every edge that follows an issued stimulus yields one output vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL vector op=%b rst=%b: got %b expected %b", e.op, e.r, act, e.vec);
                end
                checks++;
                if (memwrite_d && memread_d) begin
                    errors++;
                    $display("FAIL mem_excl op=%b: memwrite=%b memread=%b expected not both 1",
                             e.op, memwrite_d, memread_d);
                end
                checks++;
                if (jumppc_d && bne_d) begin
                    errors++;
                    $display("FAIL jump_excl op=%b: jumppc=%b bne=%b expected not both 1",
                             e.op, jumppc_d, bne_d);
                end
            end
        end
    end

    initial begin
        logic [6:0] known [9];
        table_m[7'b0110011] = 14'b1_0110_1_0_0_0_00_0_0_0;
        table_m[7'b0010011] = NOP;
        table_m[7'b0000000] = NOP;
        table_m[7'b0000011] = 14'b1_0000_1_1_0_1_01_0_0_0;
        table_m[7'b0100011] = 14'b0_0000_1_1_1_0_00_0_0_0;
        table_m[7'b1100011] = 14'b0_0001_1_0_0_0_00_0_0_1;
        table_m[7'b0110111] = 14'b1_0010_0_1_0_0_00_0_0_0;
        table_m[7'b1101111] = 14'b1_0000_1_1_0_0_10_1_0_0;
        table_m[7'b1100111] = 14'b1_0000_1_1_0_0_10_1_1_0;
        known = '{7'b0110011, 7'b0010011, 7'b0000000, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111};

        rst      = 1'b1;
        opcode_d = 7'b0;

        // Reset held with an R-type opcode present
        apply(1'b1, 7'b0110011);
        apply(1'b1, 7'b0110011);
        // Bubble, then first real decode
        apply(1'b0, 7'b0000000);
        apply(1'b0, 7'b0110011);
        apply(1'b0, 7'b0000011);
        apply(1'b0, 7'b0100011);
        apply(1'b0, 7'b1100011);
        apply(1'b0, 7'b0110111);
        apply(1'b0, 7'b1101111);
        apply(1'b0, 7'b1100111);
        apply(1'b0, 7'b1111111);
        // Reset pulse while a store is held
        apply(1'b0, 7'b0100011);
        apply(1'b1, 7'b0100011);
        apply(1'b0, 7'b0100011);
        apply(1'b0, 7'b0100011);

        for (int unsigned i = 0; i < 128; i++) begin
            apply(1'b0, 7'(i));
        end

        for (int unsigned i = 0; i < 400; i++) begin
            logic       r;
            logic [6:0] op;
            r = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) op = known[$urandom_range(0, 8)];
            else op = 7'($urandom);
            apply(r, op);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d vectors never observed, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
